// File: rtl/keypad_pkg.sv
// Purpose: shared types, command codes and hex-to-7-segment decode for the keypad/display controller.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_CLR  = 4'hC;
    localparam key_code_t KEY_BKSP = 4'hD;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        CANDIDATE = 2'd1,
        PRESSED   = 2'd2
    } deb_state_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/keypad_display_ctrl_seg7_mux.sv
// Purpose: time-multiplexes DIGITS hex nibbles onto one common 7-segment display.
// Latency: a new digit/segment pair is presented every REFRESH_DIV cycles, both registered on the same edge.
// Backpressure: none; free-running, samples value at each refresh tick.
module seg7_mux
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 25000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   value,
    output logic [7:0]            display8,
    output logic [DIGITS-1:0]     bitchoose
);

    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int DW = $clog2(DIGITS);

    logic [RW-1:0] refresh_cnt;
    logic [DW-1:0] digit_idx;
    logic          tick;

    assign tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

    // Refresh divider; on each tick present the current digit and advance to the next
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            display8    <= 8'hFF;
            bitchoose   <= '1;
        end else begin
            if (tick) begin
                refresh_cnt <= '0;
                // Select and segments load together so no digit shows a neighbour's pattern
                bitchoose   <= ~(DIGITS'(1) << digit_idx);
                display8    <= {1'b1, seg7_hex(value[4*digit_idx +: 4])};
                digit_idx   <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_display_ctrl.sv
// Purpose: 4x4 keypad scan, whole-frame debounce, hex entry shift register and muxed 7-seg display.
// Latency: keyValid DEBOUNCE_N frames (+2 sync cycles, up to +1 frame) after rows settle; one-cycle pulse.
// Backpressure: none; accepted keys are applied immediately. Build option KEYPAD_CMD_EN makes C=clear, D=backspace.
module keypad_display_ctrl
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE_N  = 4,
    parameter int REFRESH_DIV = 25000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [3:0]            keyRows,
    output logic [3:0]            keyCols,
    output logic                  keyValid,
    output logic [3:0]            keyCode,
    output logic [4*DIGITS-1:0]   value,
    output logic [7:0]            display8,
    output logic [DIGITS-1:0]     bitchoose
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_N + 1);

    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    col_idx;
    logic          step_end;
    logic          frame_end;
    logic          col_hit;
    key_code_t     col_code;
    logic          acc_hit;
    key_code_t     acc_code;
    logic          frame_hit;
    key_code_t     frame_code;
    deb_state_t    deb_state;
    logic [CW-1:0] deb_cnt;
    key_code_t     cand_code;

    // Apply an accepted key to the entry register
    function automatic logic [4*DIGITS-1:0] next_value(input logic [4*DIGITS-1:0] cur,
                                                       input key_code_t k);
`ifdef KEYPAD_CMD_EN
        if (k == KEY_CLR)  return '0;
        if (k == KEY_BKSP) return {4'h0, cur[4*DIGITS-1:4]};
`endif
        return {cur[4*DIGITS-5:0], k};
    endfunction

    assign step_end  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_end = step_end && (col_idx == 2'd3);
    assign keyCols   = ~(4'b0001 << col_idx);

    // Two-flop synchroniser for the asynchronous row inputs (idle = pulled-up high)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= keyRows;
            rows_sync <= rows_meta;
        end
    end

    // Column step divider and column index
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (step_end) begin
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Lowest-numbered low row in the column currently driven
    always_comb begin
        col_hit  = 1'b0;
        col_code = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_sync[r]) begin
                col_hit  = 1'b1;
                col_code = {r[1:0], col_idx};
            end
        end
    end

    // Earlier columns win; the last column's sample is folded in combinationally at frame end
    assign frame_hit  = acc_hit | col_hit;
    assign frame_code = acc_hit ? acc_code : col_code;

    // Per-frame accumulator holding the first key seen in scan order
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_hit  <= 1'b0;
            acc_code <= 4'h0;
        end else if (frame_end) begin
            acc_hit  <= 1'b0;
            acc_code <= 4'h0;
        end else if (step_end && col_hit && !acc_hit) begin
            acc_hit  <= 1'b1;
            acc_code <= col_code;
        end
    end

    // Frame-rate debounce FSM with registered accept pulse, code and value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_state <= RELEASED;
            deb_cnt   <= '0;
            cand_code <= 4'h0;
            keyValid  <= 1'b0;
            keyCode   <= 4'h0;
            value     <= '0;
        end else begin
            keyValid <= 1'b0;
            if (frame_end) begin
                case (deb_state)
                    RELEASED: begin
                        if (frame_hit) begin
                            if (DEBOUNCE_N == 1) begin
                                deb_state <= PRESSED;
                                deb_cnt   <= '0;
                                keyValid  <= 1'b1;
                                keyCode   <= frame_code;
                                value     <= next_value(value, frame_code);
                            end else begin
                                deb_state <= CANDIDATE;
                                deb_cnt   <= CW'(1);
                                cand_code <= frame_code;
                            end
                        end
                    end
                    CANDIDATE: begin
                        if (!frame_hit) begin
                            deb_state <= RELEASED;
                            deb_cnt   <= '0;
                        end else if (frame_code != cand_code) begin
                            cand_code <= frame_code;
                            deb_cnt   <= CW'(1);
                        end else if (deb_cnt == CW'(DEBOUNCE_N - 1)) begin
                            deb_state <= PRESSED;
                            deb_cnt   <= '0;
                            keyValid  <= 1'b1;
                            keyCode   <= frame_code;
                            value     <= next_value(value, frame_code);
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        // Any key (even a different one) keeps us held; only a clean release re-arms
                        if (frame_hit) begin
                            deb_cnt <= '0;
                        end else if (deb_cnt == CW'(DEBOUNCE_N - 1)) begin
                            deb_state <= RELEASED;
                            deb_cnt   <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: begin
                        deb_state <= RELEASED;
                        deb_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    seg7_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_seg7_mux (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .value     (value),
        .display8  (display8),
        .bitchoose (bitchoose)
    );

endmodule

// File: tb/tb_keypad_display_ctrl.sv
// Purpose: self-checking bench for keypad_display_ctrl with a frame-level behavioural model.
// Latency: stimulus changes only at frame boundaries so each frame's result is unambiguous.
// Backpressure: n/a.
module tb_keypad_display_ctrl;

    localparam int DIGITS      = 4;
    localparam int SCAN_DIV    = 4;
    localparam int DEBOUNCE_N  = 3;
    localparam int REFRESH_DIV = 2;
    localparam int FRAME       = 4 * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  keyRows;
    logic [3:0]  keyCols;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic [15:0] value;
    logic [7:0]  display8;
    logic [3:0]  bitchoose;

    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int passed = 0;

    // Reference model state
    int          hist[$];
    bit          armed = 1'b1;
    logic [15:0] mval  = 16'h0;
    logic [3:0]  mcode = 4'h0;
    logic [7:0]  seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    keypad_display_ctrl #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_N  (DEBOUNCE_N),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .keyRows   (keyRows),
        .keyCols   (keyCols),
        .keyValid  (keyValid),
        .keyCode   (keyCode),
        .value     (value),
        .display8  (display8),
        .bitchoose (bitchoose)
    );

    always #5 CLK = ~CLK;

    // Passive keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        keyRows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keyCols[c]) keyRows[r] = 1'b0;
    end

    function automatic int scan_first(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4+c]) return r*4 + c;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        armed = 1'b1;
        mval  = 16'h0;
        mcode = 4'h0;
    endtask

    // Accept when the last DEBOUNCE_N frames all show the same key and the pad was released;
    // re-arm once the last DEBOUNCE_N frames are all empty.
    task automatic model_frame(input logic [15:0] m, output int exp_acc);
        int res;
        bit same;
        bit empty;
        res = scan_first(m);
        hist.push_back(res);
        if (hist.size() > DEBOUNCE_N) void'(hist.pop_front());
        exp_acc = 0;
        if (hist.size() == DEBOUNCE_N) begin
            same  = 1'b1;
            empty = 1'b1;
            foreach (hist[i]) begin
                if (hist[i] != res) same = 1'b0;
                if (hist[i] >= 0)   empty = 1'b0;
            end
            if (armed && res >= 0 && same) begin
                exp_acc = 1;
                armed   = 1'b0;
                mcode   = res[3:0];
`ifdef KEYPAD_CMD_EN
                if (res == 12)      mval = 16'h0;
                else if (res == 13) mval = 16'(int'(mval) / 16);
                else                mval = 16'((int'(mval) * 16 + res) % 65536);
`else
                mval = 16'((int'(mval) * 16 + res) % 65536);
`endif
            end
            if (empty) armed = 1'b1;
        end
    endtask

    // Hold a key mask for one full frame (entered and left at a negedge); count keyValid cycles
    task automatic drive_frame(input logic [15:0] m, output int pulses, output int exp_acc);
        pressed = m;
        pulses  = 0;
        repeat (FRAME) begin
            @(posedge CLK);
            @(negedge CLK);
            if (keyValid === 1'b1) pulses++;
        end
        model_frame(m, exp_acc);
    endtask

    task automatic drive_frames(input logic [15:0] m, input int n, inout int pulses, inout int exp_acc);
        int p;
        int e;
        for (int i = 0; i < n; i++) begin
            drive_frame(m, p, e);
            pulses  += p;
            exp_acc += e;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N   = 1'b0;
        pressed = 16'h0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int p;
        int e;
        p = 0;
        e = 0;
        drive_frames(16'h0020, 2, p, e);
        repeat (7) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        checks++; if (keyCols !== 4'b1110) $display("FAIL reset_keyCols: got %b expected 1110", keyCols); else passed++;
        checks++; if (keyValid !== 1'b0) $display("FAIL reset_keyValid: got %b expected 0", keyValid); else passed++;
        checks++; if (keyCode !== 4'h0) $display("FAIL reset_keyCode: got %h expected 0", keyCode); else passed++;
        checks++; if (value !== 16'h0) $display("FAIL reset_value: got %h expected 0000", value); else passed++;
        checks++; if (display8 !== 8'hFF) $display("FAIL reset_display8: got %h expected ff", display8); else passed++;
        checks++; if (bitchoose !== 4'hF) $display("FAIL reset_bitchoose: got %b expected 1111", bitchoose); else passed++;
        pressed = 16'h0;
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        checks++; if (keyCols !== 4'b1110) $display("FAIL post_reset_keyCols: got %b expected 1110", keyCols); else passed++;
        repeat (FRAME - 1) @(posedge CLK);
        @(negedge CLK);
        model_frame(16'h0, e);
        p = 0;
        e = 0;
        drive_frames(16'h0, 3, p, e);
        checks++; if (p !== 0) $display("FAIL reset_no_pulse: got %0d pulses expected 0", p); else passed++;
    endtask

    task automatic test_hold_key5();
        int p;
        int e;
        p = 0;
        e = 0;
        drive_frames(16'h0020, DEBOUNCE_N, p, e);
        checks++; if (p !== 1) $display("FAIL hold5_pulse: got %0d expected 1", p); else passed++;
        checks++; if (keyCode !== 4'h5) $display("FAIL hold5_code: got %h expected 5", keyCode); else passed++;
        checks++; if (value !== 16'h0005) $display("FAIL hold5_value: got %h expected 0005", value); else passed++;
        drive_frames(16'h0020, 10, p, e);
        checks++; if (p !== e || p !== 1) $display("FAIL hold5_no_repeat: got %0d pulses expected %0d", p, e); else passed++;
        drive_frames(16'h0, DEBOUNCE_N, p, e);
    endtask

    task automatic test_sequence();
        int keys [5] = '{1, 2, 3, 4, 9};
        int p;
        int e;
        foreach (keys[k]) begin
            p = 0;
            e = 0;
            drive_frames(16'(1 << keys[k]), DEBOUNCE_N, p, e);
            drive_frames(16'h0, DEBOUNCE_N, p, e);
            checks++; if (p !== 1 || e !== 1) $display("FAIL seq_pulse_%0d: got %0d expected 1 (model %0d)", keys[k], p, e); else passed++;
            checks++; if (keyCode !== 4'(keys[k])) $display("FAIL seq_code_%0d: got %h expected %h", keys[k], keyCode, 4'(keys[k])); else passed++;
        end
        checks++; if (value !== 16'h2349) $display("FAIL seq_value: got %h expected 2349", value); else passed++;
        checks++; if (value !== mval) $display("FAIL seq_value_model: got %h expected %h", value, mval); else passed++;
    endtask

    task automatic test_display();
        int n;
        int dig;
        logic [3:0] prev;
        logic [3:0] exp_sel;
        n = 0;
        while (bitchoose !== 4'b1110 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (bitchoose !== 4'b1110) $display("FAIL disp_find_digit0: got %b expected 1110", bitchoose); else passed++;
        checks++; if (display8 !== 8'h90) $display("FAIL disp_digit0_nine: got %h expected 90", display8); else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_sel = 4'(15 - (1 << i));
            dig     = (int'(mval) / (1 << (4*i))) % 16;
            checks++; if (bitchoose !== exp_sel) $display("FAIL disp_sel_%0d: got %b expected %b", i, bitchoose, exp_sel); else passed++;
            checks++; if (display8 !== seg_ref[dig]) $display("FAIL disp_seg_%0d: got %h expected %h", i, display8, seg_ref[dig]); else passed++;
            prev = bitchoose;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (bitchoose === prev && n < 10);
            checks++; if (n !== REFRESH_DIV) $display("FAIL disp_period_%0d: got %0d cycles expected %0d", i, n, REFRESH_DIV); else passed++;
        end
        checks++; if (bitchoose !== 4'b1110) $display("FAIL disp_wrap: got %b expected 1110", bitchoose); else passed++;
        // Return to a frame boundary: the next frame starts on a multiple of FRAME posedges
        // since reset; re-align by resetting and rebuilding the model state.
        do_reset();
    endtask

    task automatic test_bounce();
        int p;
        int e;
        p = 0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            drive_frames(16'h0040, 2, p, e);
            drive_frames(16'h0, 1, p, e);
        end
        checks++; if (p !== 0 || e !== 0) $display("FAIL bounce_pulse: got %0d expected 0 (model %0d)", p, e); else passed++;
        drive_frames(16'h0081, DEBOUNCE_N, p, e);
        checks++; if (p !== 1) $display("FAIL multi_pulse: got %0d expected 1", p); else passed++;
        checks++; if (keyCode !== 4'h0) $display("FAIL multi_code: got %h expected 0", keyCode); else passed++;
        checks++; if (value !== mval) $display("FAIL multi_value: got %h expected %h", value, mval); else passed++;
        drive_frames(16'h0, DEBOUNCE_N, p, e);
    endtask

    task automatic test_release_short();
        int p;
        int e;
        int exp_p [6] = '{1, 0, 0, 0, 1, 0};
        int n_fr [6]  = '{3, 2, 3, 3, 3, 3};
        logic [15:0] msk [6] = '{16'h0080, 16'h0, 16'h0080, 16'h0, 16'h0080, 16'h0};
        for (int s = 0; s < 6; s++) begin
            p = 0;
            e = 0;
            drive_frames(msk[s], n_fr[s], p, e);
            checks++; if (p !== exp_p[s] || e !== exp_p[s]) $display("FAIL release_phase_%0d: got %0d pulses expected %0d (model %0d)", s, p, exp_p[s], e); else passed++;
        end
        checks++; if (value !== mval) $display("FAIL release_value: got %h expected %h", value, mval); else passed++;
    endtask

    task automatic press_key(input int k);
        int p;
        int e;
        p = 0;
        e = 0;
        drive_frames(16'(1 << k), DEBOUNCE_N, p, e);
        drive_frames(16'h0, DEBOUNCE_N, p, e);
    endtask

    task automatic test_cmd();
        do_reset();
        press_key(1);
        press_key(2);
        press_key(3);
        press_key(4);
        checks++; if (value !== 16'h1234) $display("FAIL cmd_entry: got %h expected 1234", value); else passed++;
`ifdef KEYPAD_CMD_EN
        press_key(13);
        checks++; if (value !== 16'h0123) $display("FAIL cmd_bksp: got %h expected 0123", value); else passed++;
        checks++; if (keyCode !== 4'hD) $display("FAIL cmd_bksp_code: got %h expected d", keyCode); else passed++;
        press_key(12);
        checks++; if (value !== 16'h0000) $display("FAIL cmd_clr: got %h expected 0000", value); else passed++;
`else
        press_key(12);
        checks++; if (value !== 16'h234C) $display("FAIL cmd_plain_c: got %h expected 234c", value); else passed++;
`endif
        checks++; if (keyCode !== 4'hC) $display("FAIL cmd_code: got %h expected c", keyCode); else passed++;
        checks++; if (value !== mval) $display("FAIL cmd_model: got %h expected %h", value, mval); else passed++;
    endtask

    task automatic test_random();
        int p;
        int e;
        int len;
        int kind;
        logic [15:0] m;
        for (int seg = 0; seg < 25; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       m = 16'h0;
                3:       m = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: m = 16'(1 << $urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 4);
            for (int f = 0; f < len; f++) begin
                drive_frame(m, p, e);
                checks++; if (p !== e) $display("FAIL rand_pulse_s%0d_f%0d: got %0d expected %0d", seg, f, p, e); else passed++;
            end
            checks++; if (value !== mval) $display("FAIL rand_value_s%0d: got %h expected %h", seg, value, mval); else passed++;
            checks++; if (keyCode !== mcode) $display("FAIL rand_code_s%0d: got %h expected %h", seg, keyCode, mcode); else passed++;
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_hold_key5();
        test_sequence();
        test_display();
        test_bounce();
        test_release_short();
        test_cmd();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
